// File: rtl/if_fetch_buffer.sv
// Instruction fetch buffer: circular FIFO of (pc, instr) pairs between fetch and decode.
// Optional same-cycle empty-buffer bypass to decode when IF_FETCH_BUF_BYPASS_EN is defined.
module if_fetch_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic bypass_hit;
    logic do_write;
    logic do_read;

    assign full     = (cnt_q == FULL_CNT);
    assign empty    = (cnt_q == '0);
    assign in_ready = rst_n && !full;
    assign push     = in_valid && in_ready;
    assign count    = cnt_q;

`ifdef IF_FETCH_BUF_BYPASS_EN
    // Gated by push so a pair fetch does not consider accepted never reaches decode.
    assign bypass_hit = empty && push && !flush;
    assign out_valid  = !empty || bypass_hit;
    assign out_pc     = bypass_hit ? in_pc    : pc_mem_q[rd_ptr_q];
    assign out_instr  = bypass_hit ? in_instr : instr_mem_q[rd_ptr_q];
`else
    assign bypass_hit = 1'b0;
    assign out_valid  = !empty;
    assign out_pc     = pc_mem_q[rd_ptr_q];
    assign out_instr  = instr_mem_q[rd_ptr_q];
`endif

    assign pop      = out_valid && out_ready;
    // A bypassed pair that decode takes straight away is never stored.
    assign do_write = push && !(bypass_hit && out_ready);
    assign do_read  = pop && !bypass_hit;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_write, do_read})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is cleared on reset so empty-state outputs read zero rather than X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (!flush && do_write) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

    a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= FULL_CNT);

    a_ptr_cnt_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        PTR_W'(wr_ptr_q - rd_ptr_q) == cnt_q[PTR_W-1:0]);

endmodule
